mem_access: RTL

//  Memory stage of the in-order RV32I pipeline, directly downstream of execute.

---
 rtl/mem_access.sv | 87 ++++++++
 1 files changed

// File: rtl/mem_access.sv
// mem_access: RV32I memory stage; drives a req/gnt/rvalid data port, formats loads, stalls upstream while an access is outstanding.
module mem_access #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr_i,
  input  logic [31:0]       alu_result_i,
  input  logic [31:0]       store_data_i,
  output logic              stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic [31:0]       instr_o,
  output logic [31:0]       wb_data_o,
  output logic              misaligned_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t      state, state_nxt;
  logic [6:0]  opcode;
  logic [2:0]  f3, f3_q;
  logic [1:0]  off, off_q;
  logic        is_load, is_store, misal, mem_op, in_wait, done;
  logic [31:0] d, load_data;
  assign opcode   = instr_i[6:0];
  assign f3       = instr_i[14:12];
  assign off      = alu_result_i[1:0];
  assign is_load  = opcode == 7'b0000011 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b101);
  assign is_store = opcode == 7'b0100011 && (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
  assign misal    = (is_load || is_store) && ((f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00));
  // Gated by rst_n so a held mem op cannot raise req while reset is asserted
  assign mem_op   = rst_n && (is_load || is_store) && !misal;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  always_comb
    state_nxt = state == WAIT ? (dmem_rvalid_i ? IDLE : WAIT) :
                !mem_op       ? IDLE :
                !dmem_gnt_i   ? REQ  :
                is_load       ? WAIT : IDLE;
  always_comb begin
    in_wait    = state == WAIT;
    dmem_req_o = mem_op && !in_wait;
    done       = in_wait ? dmem_rvalid_i : mem_op && dmem_gnt_i && is_store;
    stall_o    = in_wait ? !dmem_rvalid_i : mem_op && !done;
  end
  always_comb begin
    dmem_addr_o  = {alu_result_i[ADDR_W-1:2], 2'b00};
    dmem_we_o    = is_store;
    dmem_be_o    = !is_store           ? 4'b1111 :
                   f3[1:0] == 2'b00    ? 4'b0001 << off :
                   f3[1:0] == 2'b01    ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    dmem_wdata_o = f3[1:0] == 2'b00 ? {4{store_data_i[7:0]}} :
                   f3[1:0] == 2'b01 ? {2{store_data_i[15:0]}} : store_data_i;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      off_q <= 2'b00;
      f3_q  <= 3'b000;
    end else if (dmem_req_o && dmem_gnt_i && is_load) begin
      off_q <= off;
      f3_q  <= f3;
    end
  always_comb begin
    d         = dmem_rdata_i >> {off_q, 3'b000};
    load_data = f3_q == 3'b000 ? {{24{d[7]}}, d[7:0]} :
                f3_q == 3'b001 ? {{16{d[15]}}, d[15:0]} :
                f3_q == 3'b100 ? {24'b0, d[7:0]} :
                f3_q == 3'b101 ? {16'b0, d[15:0]} : dmem_rdata_i;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      instr_o      <= 32'b0;
      wb_data_o    <= 32'b0;
      misaligned_o <= 1'b0;
    end else begin
      instr_o      <= stall_o ? NOP_INSTR : instr_i;
      wb_data_o    <= stall_o ? 32'b0 : in_wait ? load_data : done ? 32'b0 : alu_result_i;
      misaligned_o <= !stall_o && misal;
    end
endmodule
